// File: rtl/ad_capture_arbiter_if.sv
// Bus bundle between the capture arbiter, the channel engines, the FIFO and the MCU.
interface ad_capture_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 12,
  parameter int CH_W   = 2
);
  logic                   arb_enable;
  logic                   one_second_clk;
  logic                   fifo_idle;
  logic                   mcu_ack;
  logic [NUM_CH-1:0]      ch_start;
  logic [NUM_CH-1:0]      ch_done;
  logic [NUM_CH-1:0]      ch_wr_en;
  logic [NUM_CH*DW-1:0]   ch_wr_data;
  logic [NUM_CH-1:0]      ch_save_enable;
  logic                   fifo_wr_en;
  logic [DW-1:0]          fifo_wr_data;
  logic                   irq;
  logic [CH_W-1:0]        active_ch;
  logic [31:0]            event_sec;
  logic                   timeout_flag;
  logic                   busy;

  // Arbiter side.
  modport slave (
    input  arb_enable, one_second_clk, fifo_idle, mcu_ack,
    input  ch_start, ch_done, ch_wr_en, ch_wr_data,
    output ch_save_enable, fifo_wr_en, fifo_wr_data, irq,
    output active_ch, event_sec, timeout_flag, busy
  );

  // Engines / FIFO / MCU side.
  modport master (
    output arb_enable, one_second_clk, fifo_idle, mcu_ack,
    output ch_start, ch_done, ch_wr_en, ch_wr_data,
    input  ch_save_enable, fifo_wr_en, fifo_wr_data, irq,
    input  active_ch, event_sec, timeout_flag, busy
  );
endinterface

// File: rtl/ad_capture_arbiter.sv
// Round-robin arbiter sharing one capture FIFO write port between NUM_CH
// AD9238 capture engines, with event timestamping, MCU interrupt and hold-off.
module ad_capture_arbiter #(
  parameter int NUM_CH            = 4,
  parameter int DW                = 12,
  parameter int CH_W              = 2,
  parameter int CAPTURE_TIMEOUT_S = 2,
  parameter int READ_TIMEOUT_S    = 10,
  parameter int HOLDOFF_CYC       = 1000
) (
  input  logic                 clk_100m,
  input  logic                 reset_n,
  ad_capture_arbiter_if.slave  bus
);

  localparam int PW = CH_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_NOTIFY,
    S_HOLDOFF
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [1:0]          r_sync;
  logic                r_sec_prev;
  logic [31:0]         r_sec_cnt;
  logic                w_sec_tick;

  logic [31:0]         r_to_cnt;
  logic [31:0]         w_to_cnt_nxt;
  logic [31:0]         r_ho_cnt;
  logic [31:0]         w_ho_cnt_nxt;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     w_ptr_nxt;

  logic [NUM_CH-1:0]   r_save_en,  w_save_en_nxt;
  logic                r_wr_en,    w_wr_en_nxt;
  logic [DW-1:0]       r_wr_data,  w_wr_data_nxt;
  logic                r_irq,      w_irq_nxt;
  logic [CH_W-1:0]     r_active,   w_active_nxt;
  logic [31:0]         r_event,    w_event_nxt;
  logic                r_to_flag,  w_to_flag_nxt;
  logic                r_busy,     w_busy_nxt;

  logic [NUM_CH-1:0]   w_req;
  logic                w_grant;
  logic [CH_W-1:0]     w_winner;
  logic [CH_W-1:0]     w_winner_inc;

  assign w_sec_tick = r_sync[1] & ~r_sec_prev;

  // Synchronise the 1 Hz clock and keep the free-running seconds counter.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= '0;
      r_sec_prev <= 1'b0;
      r_sec_cnt  <= '0;
    end else begin
      r_sync     <= {r_sync[0], bus.one_second_clk};
      r_sec_prev <= r_sync[1];
      if (w_sec_tick) r_sec_cnt <= r_sec_cnt + 32'd1;
    end
  end

  // Round-robin search: first armed start request at or after the pointer.
  always_comb begin
    logic [PW-1:0] v_sum;
    logic [PW-1:0] v_inc;
    v_sum        = '0;
    v_inc        = '0;
    w_grant      = 1'b0;
    w_winner     = '0;
    w_req        = bus.ch_start & r_save_en & {NUM_CH{bus.arb_enable}};
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      v_sum = {1'b0, r_ptr} + PW'(i);
      if (v_sum >= PW'(NUM_CH)) v_sum = v_sum - PW'(NUM_CH);
      if (!w_grant && w_req[v_sum[CH_W-1:0]]) begin
        w_grant  = 1'b1;
        w_winner = v_sum[CH_W-1:0];
      end
    end
    v_inc = {1'b0, w_winner} + PW'(1);
    if (v_inc >= PW'(NUM_CH)) v_inc = '0;
    w_winner_inc = v_inc[CH_W-1:0];
  end

  // Next state and next values of every registered output.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_active_nxt  = r_active;
    w_event_nxt   = r_event;
    w_to_flag_nxt = r_to_flag;
    w_save_en_nxt = '0;
    w_wr_en_nxt   = 1'b0;
    w_wr_data_nxt = '0;
    w_irq_nxt     = 1'b0;
    w_busy_nxt    = 1'b0;
    w_to_cnt_nxt  = '0;
    w_ho_cnt_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt   = S_CAPTURE;
          w_active_nxt  = w_winner;
          w_event_nxt   = r_sec_cnt;
          w_to_flag_nxt = 1'b0;
          w_ptr_nxt     = w_winner_inc;
        end
      end
      S_CAPTURE: begin
        if (bus.ch_done[r_active]) begin
          w_state_nxt = S_NOTIFY;
        end else if (r_to_cnt >= 32'(CAPTURE_TIMEOUT_S)) begin
          w_state_nxt   = S_HOLDOFF;
          w_to_flag_nxt = 1'b1;
        end
      end
      S_NOTIFY: begin
        if (bus.mcu_ack) begin
          w_state_nxt = S_HOLDOFF;
        end else if (r_to_cnt >= 32'(READ_TIMEOUT_S)) begin
          w_state_nxt   = S_HOLDOFF;
          w_to_flag_nxt = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (r_ho_cnt >= 32'(HOLDOFF_CYC - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Disable overrides everything but keeps the event record intact.
    if (!bus.arb_enable) begin
      w_state_nxt   = S_IDLE;
      w_ptr_nxt     = r_ptr;
      w_active_nxt  = r_active;
      w_event_nxt   = r_event;
      w_to_flag_nxt = r_to_flag;
    end

    case (w_state_nxt)
      S_IDLE:    w_save_en_nxt = (bus.arb_enable && bus.fifo_idle) ? '1 : '0;
      S_CAPTURE: w_save_en_nxt[w_active_nxt] = 1'b1;
      default:   w_save_en_nxt = '0;
    endcase

    // Writes only pass while the capture continues, so NOTIFY never shows a strobe.
    if (r_state == S_CAPTURE && w_state_nxt == S_CAPTURE && bus.ch_wr_en[r_active]) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_data_nxt = bus.ch_wr_data[r_active*DW +: DW];
    end

    w_irq_nxt  = (w_state_nxt == S_NOTIFY);
    w_busy_nxt = (w_state_nxt != S_IDLE);

    if (w_state_nxt == r_state) begin
      w_to_cnt_nxt = r_to_cnt + {31'd0, w_sec_tick};
      if (r_state == S_HOLDOFF) w_ho_cnt_nxt = r_ho_cnt + 32'd1;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk_100m or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_to_cnt  <= '0;
      r_ho_cnt  <= '0;
      r_save_en <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_irq     <= 1'b0;
      r_active  <= '0;
      r_event   <= '0;
      r_to_flag <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_ho_cnt  <= w_ho_cnt_nxt;
      r_save_en <= w_save_en_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_irq     <= w_irq_nxt;
      r_active  <= w_active_nxt;
      r_event   <= w_event_nxt;
      r_to_flag <= w_to_flag_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign bus.ch_save_enable = r_save_en;
  assign bus.fifo_wr_en     = r_wr_en;
  assign bus.fifo_wr_data   = r_wr_data;
  assign bus.irq            = r_irq;
  assign bus.active_ch      = r_active;
  assign bus.event_sec      = r_event;
  assign bus.timeout_flag   = r_to_flag;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_ad_capture_arbiter.sv
// Directed bench for ad_capture_arbiter with a write-data scoreboard.
module tb_ad_capture_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 12;
  localparam int CH_W   = 2;

  logic clk_100m = 1'b0;
  logic reset_n  = 1'b0;

  ad_capture_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW), .CH_W(CH_W)) bus ();

  ad_capture_arbiter #(
    .NUM_CH(NUM_CH), .DW(DW), .CH_W(CH_W),
    .CAPTURE_TIMEOUT_S(2), .READ_TIMEOUT_S(10), .HOLDOFF_CYC(1000)
  ) dut (
    .clk_100m (clk_100m),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 clk_100m = ~clk_100m;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;
  int irq_cnt = 0;
  int sec_model = 0;
  int grant_sec = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic sec_edge();
    bus.one_second_clk = 1'b1;
    repeat (6) tick();
    bus.one_second_clk = 1'b0;
    repeat (6) tick();
    sec_model++;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 1200) begin
      tick();
      k++;
    end
    check(tag, bus.busy, 1'b0);
  endtask

  // FIFO-side scoreboard: every strobe must match the oldest pushed sample.
  always @(negedge clk_100m) begin
    if (reset_n && bus.fifo_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) check("wr_unexpected", bus.fifo_wr_en, 1'b0);
      else check("wr_data", bus.fifo_wr_data, exp_q.pop_front());
    end
  end

  always @(negedge clk_100m) if (bus.irq === 1'b1) irq_cnt++;

  initial begin
    bus.arb_enable     = 1'b0;
    bus.one_second_clk = 1'b0;
    bus.fifo_idle      = 1'b0;
    bus.mcu_ack        = 1'b0;
    bus.ch_start       = '0;
    bus.ch_done        = '0;
    bus.ch_wr_en       = '0;
    bus.ch_wr_data     = '0;
    repeat (3) tick();

    check("rst_arms",   bus.ch_save_enable, 4'b0000);
    check("rst_wr_en",  bus.fifo_wr_en, 1'b0);
    check("rst_wr_dat", bus.fifo_wr_data, 12'h000);
    check("rst_irq",    bus.irq, 1'b0);
    check("rst_active", bus.active_ch, 2'd0);
    check("rst_event",  bus.event_sec, 32'd0);
    check("rst_toflag", bus.timeout_flag, 1'b0);
    check("rst_busy",   bus.busy, 1'b0);

    reset_n = 1'b1;
    bus.arb_enable = 1'b1;
    bus.fifo_idle  = 1'b1;
    tick();
    check("arm_idle", bus.ch_save_enable, 4'b1111);

    // Arbitration from reset
    bus.ch_start = 4'b0100;
    tick();
    bus.ch_start = '0;
    check("grant_active", bus.active_ch, 2'd2);
    check("grant_arms",   bus.ch_save_enable, 4'b0100);
    check("grant_busy",   bus.busy, 1'b1);
    check("grant_event",  bus.event_sec, 32'(sec_model));

    // Write muxing: 4096 on ch2, 100 on ch0 (discarded)
    for (int i = 0; i < 4096; i++) begin
      logic [DW-1:0] d2;
      d2 = i[11:0] ^ 12'hA5C;
      bus.ch_wr_en = {2'b01, 1'b0, (i < 100)};
      bus.ch_wr_data = '0;
      bus.ch_wr_data[2*DW +: DW] = d2;
      bus.ch_wr_data[0 +: DW]    = ~d2;
      exp_q.push_back(d2);
      tick();
    end
    bus.ch_wr_en = '0;
    repeat (3) tick();
    check("wr_count", 64'(n_wr), 64'd4096);
    check("wr_q_empty", 64'(exp_q.size()), 64'd0);

    // Notify / acknowledge / hold-off
    bus.ch_done = 4'b0100;
    tick();
    bus.ch_done = '0;
    check("notify_irq", bus.irq, 1'b1);
    check("notify_arms", bus.ch_save_enable, 4'b0000);
    for (int i = 0; i < 49; i++) begin
      tick();
      check("notify_irq_hold", bus.irq, 1'b1);
    end
    bus.mcu_ack = 1'b1;
    tick();
    bus.mcu_ack = 1'b0;
    check("ack_irq",  bus.irq, 1'b0);
    check("ack_busy", bus.busy, 1'b1);
    for (int i = 0; i < 999; i++) begin
      check("holdoff_arms", bus.ch_save_enable, 4'b0000);
      tick();
    end
    check("holdoff_last_busy", bus.busy, 1'b1);
    tick();
    check("holdoff_exit_arms", bus.ch_save_enable, 4'b1111);
    check("holdoff_exit_busy", bus.busy, 1'b0);

    // Round-robin: pointer 3
    bus.ch_start = 4'b1011;
    tick();
    bus.ch_start = '0;
    check("rr1_active", bus.active_ch, 2'd3);
    check("rr1_arms",   bus.ch_save_enable, 4'b1000);
    bus.ch_done  = 4'b0001;
    bus.ch_start = 4'b0001;
    bus.mcu_ack  = 1'b1;
    tick();
    bus.ch_done  = '0;
    bus.ch_start = '0;
    bus.mcu_ack  = 1'b0;
    check("rr1_foreign_irq",  bus.irq, 1'b0);
    check("rr1_foreign_arms", bus.ch_save_enable, 4'b1000);
    check("rr1_foreign_act",  bus.active_ch, 2'd3);
    bus.arb_enable = 1'b0;
    tick();
    check("abort_busy",   bus.busy, 1'b0);
    check("abort_arms",   bus.ch_save_enable, 4'b0000);
    check("abort_active", bus.active_ch, 2'd3);
    bus.arb_enable = 1'b1;
    tick();
    check("rearm", bus.ch_save_enable, 4'b1111);
    bus.ch_start = 4'b1011;
    tick();
    bus.ch_start = '0;
    check("rr2_active", bus.active_ch, 2'd0);
    check("rr2_arms",   bus.ch_save_enable, 4'b0001);
    bus.arb_enable = 1'b0;
    tick();
    bus.arb_enable = 1'b1;
    tick();

    // Seconds counter advance while idle
    repeat (3) sec_edge();
    check("idle_arms_sec", bus.ch_save_enable, 4'b1111);

    // Capture timeout: pointer 1
    bus.ch_start = 4'b0010;
    tick();
    bus.ch_start = '0;
    grant_sec = sec_model;
    irq_cnt = 0;
    check("to_active", bus.active_ch, 2'd1);
    check("to_event",  bus.event_sec, 32'(grant_sec));
    sec_edge();
    check("to_not_early_arms", bus.ch_save_enable, 4'b0010);
    check("to_not_early_flag", bus.timeout_flag, 1'b0);
    sec_edge();
    check("to_flag",   bus.timeout_flag, 1'b1);
    check("to_busy",   bus.busy, 1'b1);
    check("to_arms",   bus.ch_save_enable, 4'b0000);
    check("to_irq",    64'(irq_cnt), 64'd0);
    check("to_event2", bus.event_sec, 32'(grant_sec));
    wait_idle("to_holdoff_exit");

    // Read timeout: pointer 2
    bus.ch_start = 4'b0100;
    tick();
    bus.ch_start = '0;
    check("rto_flag_clr", bus.timeout_flag, 1'b0);
    check("rto_event",    bus.event_sec, 32'(sec_model));
    bus.ch_done = 4'b0100;
    tick();
    bus.ch_done = '0;
    check("rto_irq", bus.irq, 1'b1);
    repeat (9) sec_edge();
    check("rto_irq_hold", bus.irq, 1'b1);
    sec_edge();
    check("rto_irq_drop", bus.irq, 1'b0);
    check("rto_flag",     bus.timeout_flag, 1'b1);
    check("rto_busy",     bus.busy, 1'b1);
    wait_idle("rto_holdoff_exit");

    // Disable during NOTIFY: pointer 3
    bus.ch_start = 4'b1000;
    tick();
    bus.ch_start = '0;
    grant_sec = sec_model;
    bus.ch_done = 4'b1000;
    tick();
    bus.ch_done = '0;
    check("dis_irq_pre", bus.irq, 1'b1);
    bus.arb_enable = 1'b0;
    tick();
    check("dis_irq",    bus.irq, 1'b0);
    check("dis_busy",   bus.busy, 1'b0);
    check("dis_arms",   bus.ch_save_enable, 4'b0000);
    check("dis_active", bus.active_ch, 2'd3);
    check("dis_event",  bus.event_sec, 32'(grant_sec));
    check("dis_flag",   bus.timeout_flag, 1'b0);

    // fifo_idle gating
    bus.arb_enable = 1'b1;
    bus.fifo_idle  = 1'b0;
    tick();
    tick();
    check("gate_arms", bus.ch_save_enable, 4'b0000);
    bus.ch_start = 4'b1111;
    tick();
    bus.ch_start = '0;
    check("gate_busy", bus.busy, 1'b0);
    tick();
    check("gate_busy2", bus.busy, 1'b0);
    check("gate_active", bus.active_ch, 2'd3);

    // Asynchronous reset mid-capture; pointer must return to 0
    bus.fifo_idle = 1'b1;
    tick();
    bus.ch_start = 4'b0010;
    tick();
    bus.ch_start = '0;
    check("pre_rst_active", bus.active_ch, 2'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",   bus.busy, 1'b0);
    check("arst_arms",   bus.ch_save_enable, 4'b0000);
    check("arst_active", bus.active_ch, 2'd0);
    check("arst_event",  bus.event_sec, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_arms", bus.ch_save_enable, 4'b1111);
    bus.ch_start = 4'b1111;
    tick();
    bus.ch_start = '0;
    check("post_rst_ptr", bus.active_ch, 2'd0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ad_capture_arbiter.md
Name: ad_capture_arbiter

Overview:
- Shares one capture FIFO write port between NUM_CH AD9238 channel capture engines.
- Each engine arms on its save-enable, pulses start when its threshold trips, streams samples, then pulses done.
- The arbiter grants the FIFO to exactly one engine per event (round-robin), disarms the others, and timestamps the event in seconds.
- It raises an interrupt to the MCU and holds off re-arming until the MCU acknowledges or a timeout expires.

Parameters:
- NUM_CH, 4, number of channel capture engines (2..8).
- DW, 12, sample width.
- CH_W, 2, width of the channel index, equal to ceil(log2(NUM_CH)).
- CAPTURE_TIMEOUT_S, 2, seconds allowed between grant and the done pulse.
- READ_TIMEOUT_S, 10, seconds allowed for the MCU to acknowledge.
- HOLDOFF_CYC, 1000, clk_100m cycles with all channels disarmed after each event.

Ports:
- clk_100m  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- arb_enable  in  1  global enable (level).
- one_second_clk  in  1  1 Hz clock, asynchronous to clk_100m.
- fifo_idle  in  1  high when the FIFO is empty or drained.
- mcu_ack  in  1  single-cycle pulse: MCU has finished reading the event.
- ch_start  in  NUM_CH  per-channel single-cycle capture-start pulse.
- ch_done  in  NUM_CH  per-channel single-cycle capture-complete pulse.
- ch_wr_en  in  NUM_CH  per-channel FIFO write strobe.
- ch_wr_data  in  NUM_CH*DW  per-channel write data; channel k occupies bits [k*DW +: DW].
- ch_save_enable  out  NUM_CH  per-channel arm.
- fifo_wr_en  out  1  muxed write strobe to the FIFO.
- fifo_wr_data  out  DW  muxed write data to the FIFO.
- irq  out  1  level interrupt to the MCU.
- active_ch  out  CH_W  index of the granted channel.
- event_sec  out  32  value of the second counter latched at grant.
- timeout_flag  out  1  sticky: the last event ended by timeout.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0; FSM state IDLE; round-robin pointer 0; second counter 0.
- Second counter:
  - one_second_clk passes through a 2-FF synchroniser, then a rising-edge detector, giving sec_tick.
  - 32-bit sec_cnt increments on each sec_tick and wraps from 0xFFFFFFFF to 0.
  - A per-state timeout counter clears on every state entry and increments on sec_tick.
- FSM states: IDLE, CAPTURE, NOTIFY, HOLDOFF. All outputs are registered.
- IDLE:
  - ch_save_enable is all-ones only when arb_enable=1 and fifo_idle=1; otherwise it is 0.
  - ch_start pulses are accepted only while they are being armed.
  - If ch_start is seen in cycle T, the state becomes CAPTURE at T+1.
- Grant rule:
  - The first set ch_start bit at index ≥ pointer, wrapping modulo NUM_CH, wins.
  - At T+1: active_ch = winner, event_sec = sec_cnt, timeout_flag cleared, pointer = (winner+1) mod NUM_CH.
  - Also at T+1, ch_save_enable = one-hot of the winner; losers drop arm at T+1.
- CAPTURE:
  - fifo_wr_en(t+1) = ch_wr_en[active_ch](t); fifo_wr_data(t+1) = the matching data slice. Latency is 1 cycle.
  - Non-granted ch_wr_en are discarded.
  - ch_done[active_ch] moves to NOTIFY and sets irq=1 on entry.
  - ch_done or ch_start from other channels is ignored.
  - If the timeout counter reaches CAPTURE_TIMEOUT_S first: timeout_flag=1, go to HOLDOFF, irq stays 0.
- NOTIFY:
  - ch_save_enable = 0 and fifo_wr_en = 0.
  - irq stays high until exit.
  - mcu_ack moves to HOLDOFF with irq=0.
  - Timeout counter reaching READ_TIMEOUT_S sets timeout_flag=1 and moves to HOLDOFF with irq=0.
  - mcu_ack in any other state is ignored.
- HOLDOFF:
  - All arms are 0.
  - A cycle counter runs HOLDOFF_CYC cycles, then returns to IDLE.
- Same-cycle priority (highest first):
  - arb_enable=0: from any state, next state is IDLE with arms, irq, fifo_wr_en and busy all 0. active_ch, event_sec and timeout_flag are held.
  - In CAPTURE, ch_done[active] beats the timeout.
  - In NOTIFY, mcu_ack beats the timeout.
- Asynchronous reset mid-operation: immediate return to reset values; the pointer resets to 0.

Test Plan:
- Arbitration from reset: reset, arb_enable=1, fifo_idle=1, then pulse ch_start[2].
  - Next cycle: state CAPTURE, active_ch=2, ch_save_enable=4'b0100, pointer=3.
- Write muxing: while channel 2 is granted, drive 4096 writes on ch 2 and 100 on ch 0.
  - fifo_wr_en shows exactly 4096 one-cycle-delayed strobes carrying channel 2 data.
- Notify/acknowledge: pulse ch_done[2], then mcu_ack 50 cycles later.
  - irq is high for 50 cycles, then 1000 HOLDOFF cycles pass with arms=0, then arms=4'b1111.
- Round-robin: pointer=3, simultaneous ch_start=4'b1011.
  - Winner is 3, then the pointer becomes 0.
  - Next simultaneous ch_start=4'b1011 → winner 0.
- Capture timeout: grant without any done, apply 2 one_second_clk edges.
  - timeout_flag=1, irq never asserted, HOLDOFF is entered.
  - event_sec equals sec_cnt as it was at grant.
- Disable and gating:
  - Drop arb_enable during NOTIFY → next cycle irq=0, busy=0, arms=0.
  - With fifo_idle=0 in IDLE, a ch_start pulse produces no grant.
